// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// byte-count decode and write-strobe generation.
package lsu_pkg;

    typedef enum logic [1:0] {
        SzB = 2'd0,
        SzH = 2'd1,
        SzW = 2'd2,
        SzD = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2,
        StDone = 2'd3
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input lsu_size_e size);
        return 4'd1 << size;
    endfunction

    // Strobe for up to an 8-byte bus; callers truncate to their own byte count.
    function automatic logic [7:0] strobe_gen(input lsu_size_e size, input logic [2:0] offset);
        logic [15:0] mask;
        mask = (16'd1 << size_bytes(size)) - 16'd1;
        mask = mask << offset;
        return mask[7:0];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: store data shift and strobes, load data
// shift, byte masking and sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  lsu_size_e                       size_i,
    input  logic                            signed_i,
    input  logic [$clog2(DATA_W/8)-1:0]     offset_i,
    input  logic [DATA_W-1:0]               wdata_i,
    input  logic [DATA_W-1:0]               rdata_i,
    output logic [DATA_W-1:0]               wdata_o,
    output logic [DATA_W/8-1:0]             wstrb_o,
    output logic [DATA_W-1:0]               rdata_o
);

    localparam int unsigned NB = DATA_W / 8;

    logic [3:0]        bytes;
    logic [DATA_W-1:0] shifted;
    logic              sign;

    assign bytes   = size_bytes(size_i);
    assign wdata_o = wdata_i << {offset_i, 3'b000};
    assign wstrb_o = NB'(strobe_gen(size_i, 3'(offset_i)));

    // Bytes shifted in from beyond the bus word are already zero, so a short
    // misaligned load extends from a zero byte.
    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        sign    = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (4'(i) == bytes - 4'd1) begin
                sign = shifted[8*i+7];
            end
        end
        rdata_o = '0;
        for (int i = 0; i < NB; i++) begin
            if (4'(i) < bytes) begin
                rdata_o[8*i +: 8] = shifted[8*i +: 8];
            end else begin
                rdata_o[8*i +: 8] = {8{sign & signed_i}};
            end
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit control: one op at a time from EXU to a req/resp memory
// port and back to WBU. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_ren,
    input  logic                in_wen,
    input  logic [1:0]          in_size,
    input  logic                in_signed,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_rdata,
    output logic                out_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_resp_rdata,
    input  logic                mem_resp_err
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned OW = $clog2(NB);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    lsu_size_e         size_q, size_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    lsu_size_e         in_sz;
    logic              illegal;
    logic              misaligned;
    logic [DATA_W-1:0] load_data;

    assign in_sz   = lsu_size_e'(in_size);
    assign illegal = (in_ren & in_wen) | ((in_sz == SzD) && (DATA_W < 64));

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = (4'(in_addr[OW-1:0]) & (size_bytes(in_sz) - 4'd1)) != 4'd0;
`else
    assign misaligned = 1'b0;
`endif

    lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size_i   (size_q),
        .signed_i (signed_q),
        .offset_i (addr_q[OW-1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (mem_resp_rdata),
        .wdata_o  (mem_req_wdata),
        .wstrb_o  (mem_req_wstrb),
        .rdata_o  (load_data)
    );

    assign mem_req_we   = we_q;
    assign mem_req_addr = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
    assign out_rdata    = rdata_q;
    assign out_err      = err_q;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        in_ready       = (state_q == StIdle);
        mem_req_valid  = (state_q == StReq);
        mem_resp_ready = (state_q == StResp);
        out_valid      = (state_q == StDone);

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    we_d     = in_wen;
                    size_d   = in_sz;
                    signed_d = in_signed;
                    addr_d   = in_addr;
                    wdata_d  = in_wdata;
                    rdata_d  = '0;
                    err_d    = 1'b0;
                    if (illegal || ((in_ren ^ in_wen) && misaligned)) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (!in_ren && !in_wen) begin
                        state_d = StDone;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (mem_req_ready) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (mem_resp_valid) begin
                    err_d   = mem_resp_err;
                    rdata_d = (mem_resp_err || we_q) ? '0 : load_data;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            size_q   <= SzB;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl (DATA_W=32): directed cases plus random ops against an
// arithmetic reference model, with a scripted memory and WBU.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_ren, in_wen, in_signed;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid, mem_resp_ready, mem_resp_err;
    logic [31:0] mem_resp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_ren         (in_ren),
        .in_wen         (in_wen),
        .in_size        (in_size),
        .in_signed      (in_signed),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rdata      (out_rdata),
        .out_err        (out_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_err   (mem_resp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Expected behaviour from the access rules, in plain integer arithmetic.
    function automatic void model(
        input  logic        ren, wen,
        input  logic [1:0]  size,
        input  logic        sgn,
        input  logic [31:0] addr, wdata, word,
        input  logic        rerr,
        output logic        bus,
        output logic [31:0] e_addr, e_wdata, e_rdata,
        output logic [3:0]  e_strb,
        output logic        e_err
    );
        longint nbytes, off, v, lim;
        logic [63:0] w64;
        nbytes  = longint'(1) << size;
        off     = longint'(addr % 4);
        w64     = {32'b0, wdata} << (8 * off);
        e_wdata = w64[31:0];
        e_addr  = addr - 32'(off);
        v       = ((64'sd1 << nbytes) - 1) << off;
        e_strb  = v[3:0];
        e_rdata = '0;
        e_err   = 1'b0;
        bus     = 1'b0;
        if ((ren && wen) || size == 2'd3) begin
            e_err = 1'b1;
        end else if (!ren && !wen) begin
            e_err = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        end else if (off % nbytes != 0) begin
            e_err = 1'b1;
`endif
        end else begin
            bus   = 1'b1;
            e_err = rerr;
            if (ren && !rerr) begin
                v   = longint'({32'b0, word}) >> (8 * off);
                v   = v & ((64'sd1 << (8 * nbytes)) - 1);
                lim = 64'sd1 << (8 * nbytes - 1);
                if (sgn && v >= lim) v = v - 2 * lim;
                e_rdata = v[31:0];
            end
        end
    endfunction

    task automatic do_op(
        input logic        ren, wen,
        input logic [1:0]  size,
        input logic        sgn,
        input logic [31:0] addr, wdata, word,
        input logic        rerr,
        input int          req_wait, resp_wait, out_wait
    );
        logic        bus, e_err;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [3:0]  e_strb;
        model(ren, wen, size, sgn, addr, wdata, word, rerr,
              bus, e_addr, e_wdata, e_rdata, e_strb, e_err);
        check("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_ren    = ren;
        in_wen    = wen;
        in_size   = size;
        in_signed = sgn;
        in_addr   = addr;
        in_wdata  = wdata;
        @(negedge clk);
        in_valid = 1'b0;
        in_addr  = $urandom;
        in_wdata = $urandom;
        in_size  = 2'($urandom);
        if (bus) begin
            for (int k = 0; k <= req_wait; k++) begin
                check("req_valid", mem_req_valid, 1);
                check("req_we", mem_req_we, wen);
                check("req_addr", mem_req_addr, e_addr);
                check("req_wdata", mem_req_wdata, e_wdata);
                check("req_wstrb", mem_req_wstrb, e_strb);
                check("in_ready_req", in_ready, 0);
                check("resp_ready_req", mem_resp_ready, 0);
                mem_req_ready = (k == req_wait);
                if (k == req_wait) begin
                    // Bogus response alongside the accept must be ignored.
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = ~word;
                    mem_resp_err   = ~rerr;
                end
                @(negedge clk);
            end
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            for (int k = 0; k <= resp_wait; k++) begin
                check("resp_ready", mem_resp_ready, 1);
                check("req_valid_resp", mem_req_valid, 0);
                check("out_valid_resp", out_valid, 0);
                if (k == resp_wait) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = word;
                    mem_resp_err   = rerr;
                end
                @(negedge clk);
            end
            mem_resp_valid = 1'b0;
            mem_resp_rdata = $urandom;
        end else begin
            check("no_bus_req", mem_req_valid, 0);
        end
        for (int k = 0; k <= out_wait; k++) begin
            check("out_valid", out_valid, 1);
            check("out_rdata", out_rdata, e_rdata);
            check("out_err", out_err, e_err);
            check("in_ready_done", in_ready, 0);
            out_ready = (k == out_wait);
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("out_valid_clr", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_rdata", out_rdata, 0);
        check("rst_out_err", out_err, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_resp_ready", mem_resp_ready, 0);
    endtask

    initial begin
        rst            = 1'b1;
        in_valid       = 1'b0;
        in_ren         = 1'b0;
        in_wen         = 1'b0;
        in_size        = 2'd0;
        in_signed      = 1'b0;
        in_addr        = '0;
        in_wdata       = '0;
        out_ready      = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        mem_resp_err   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // LW aligned, zero-wait: out_valid 3 cycles after accept.
        do_op(1, 0, 2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 0);
        // LB signed / unsigned from the top byte lane.
        do_op(1, 0, 0, 1, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 0, 0);
        do_op(1, 0, 0, 0, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 0, 0);
        // SH to upper half.
        do_op(0, 1, 1, 0, 32'h102, 32'h1234, 32'h0, 0, 0, 0, 0);
        // Misaligned LW: trapped, or issued with upper half reading as zero.
        do_op(1, 0, 2, 0, 32'h102, 32'h0, 32'hCAFEF00D, 0, 0, 0, 0);
        // Stalled request and stalled WBU.
        do_op(1, 0, 2, 1, 32'h200, 32'h0, 32'h87654321, 0, 5, 1, 3);
        // No-op, both-set, doubleword on a 32-bit bus, bus error.
        do_op(0, 0, 2, 0, 32'h300, 32'h0, 32'h0, 0, 0, 0, 0);
        do_op(1, 1, 2, 0, 32'h300, 32'h0, 32'h0, 0, 0, 0, 0);
        do_op(1, 0, 3, 0, 32'h300, 32'h0, 32'h0, 0, 0, 0, 0);
        do_op(1, 0, 1, 1, 32'h302, 32'h0, 32'hFFFFFFFF, 1, 0, 0, 0);
        do_op(0, 1, 2, 0, 32'h304, 32'hA5A5A5A5, 32'h0, 1, 0, 2, 1);

        // Reset while waiting for the response.
        in_valid  = 1'b1;
        in_ren    = 1'b1;
        in_wen    = 1'b0;
        in_size   = 2'd2;
        in_addr   = 32'h400;
        @(negedge clk);
        in_valid      = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("resp_state_before_rst", mem_resp_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();

        for (int n = 0; n < 60; n++) begin
            int          r;
            logic        ren, wen;
            r   = int'($urandom_range(0, 9));
            ren = (r == 1) || (r >= 2 && r <= 5);
            wen = (r == 1) || (r >= 6);
            do_op(ren, wen, 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
                  $urandom, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
